// File: rtl/fmul_result_stage.sv
// ---------------------------------------------------------------------------
// fmul_result_stage
//
// Registered, handshaked post-processing stage that sits directly behind the
// combinational single-precision multiplier. It captures both operands and the
// multiplier's raw result, then applies the special-case and range handling
// the multiplier does not do: NaN, infinity, zero/denormal flush, exponent
// overflow and exponent underflow.
//
// Pipeline: R1 (capture register) -> classification -> R2 (output register).
// Latency is 2 cycles from presentation, throughput is 1 result per cycle.
//
// Ports:
//   clk        single clock, all state updates on the rising edge
//   rst        synchronous, active-high reset
//   in_valid   operand/raw-result triple is valid
//   in_ready   stage can accept a triple this cycle
//   in_a       multiplicand (IEEE-754 single)
//   in_b       multiplier (IEEE-754 single)
//   in_raw     raw multiplier output for in_a, in_b
//   out_valid  out_data and flags are valid
//   out_ready  consumer accepts the output this cycle
//   out_data   final IEEE-754 product
//   out_ovf    result overflowed to infinity
//   out_udf    result underflowed / was flushed to zero by range
//   out_inv    invalid operation, out_data carries QNAN
//
// Optional feature (macro FMUL_STATS_EN):
//   op_count   16-bit saturating count of completed output handshakes
//   exc_count  16-bit saturating count of completed handshakes with a flag set
// ---------------------------------------------------------------------------
module fmul_result_stage #(
    parameter logic [31:0] QNAN = 32'h7FC00000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    input  logic [31:0] in_raw,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        out_ovf,
    output logic        out_udf,
    output logic        out_inv
`ifdef FMUL_STATS_EN
    ,
    output logic [15:0] op_count,
    output logic [15:0] exc_count
`endif
);

    // R1 capture register
    logic        r1_valid;
    logic [31:0] r1_a;
    logic [31:0] r1_b;
    logic [31:0] r1_raw;

    // Handshake terms
    logic adv2;
    logic accept;
    logic transfer;

    // Operand fields and classification
    logic [7:0]        ea;
    logic [7:0]        eb;
    logic [22:0]       ma;
    logic [22:0]       mb;
    logic              s;
    logic              a_nan;
    logic              b_nan;
    logic              a_inf;
    logic              b_inf;
    logic              a_zero;
    logic              b_zero;
    logic [7:0]        exp_sum;
    logic [7:0]        carry8;
    logic              carry;
    logic signed [9:0] texp;

    // Next values for R2
    logic [31:0] nxt_data;
    logic        nxt_ovf;
    logic        nxt_udf;
    logic        nxt_inv;

    // The sign of the product always comes from the operands, so the raw
    // result's sign bit is carried along but never consulted.
    logic raw_sign_unused;
    assign raw_sign_unused = r1_raw[31];

    // R2 can take a new value when it is empty or being drained this cycle;
    // R1 can take a new triple when it is empty or moving into R2.
    assign adv2     = !out_valid || out_ready;
    assign in_ready = !r1_valid || adv2;
    assign accept   = in_valid && in_ready;
    assign transfer = r1_valid && adv2;

    assign ea = r1_a[30:23];
    assign eb = r1_b[30:23];
    assign ma = r1_a[22:0];
    assign mb = r1_b[22:0];
    assign s  = r1_a[31] ^ r1_b[31];

    assign a_nan  = (ea == 8'hFF) && (ma != 23'd0);
    assign b_nan  = (eb == 8'hFF) && (mb != 23'd0);
    assign a_inf  = (ea == 8'hFF) && (ma == 23'd0);
    assign b_inf  = (eb == 8'hFF) && (mb == 23'd0);
    assign a_zero = (ea == 8'h00);
    assign b_zero = (eb == 8'h00);

    // The multiplier already added the exponents modulo 256 (biased sum minus
    // 127 == sum + 0x81), possibly bumped by one when the mantissa product
    // normalised upward. Recovering that bump from the raw exponent lets us
    // rebuild the true exponent with enough width to see overflow/underflow.
    assign exp_sum = ea + eb + 8'h81;
    assign carry8  = r1_raw[30:23] - exp_sum;
    assign carry   = (carry8 == 8'd1);
    assign texp    = $signed({2'b00, ea}) + $signed({2'b00, eb})
                   - 10'sd127 + $signed({9'd0, carry});

    // Classification: first match wins, at most one flag is ever raised.
    always_comb begin
        nxt_data = {s, r1_raw[30:0]};
        nxt_ovf  = 1'b0;
        nxt_udf  = 1'b0;
        nxt_inv  = 1'b0;
        if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
            nxt_data = QNAN;
            nxt_inv  = 1'b1;
        end else if (a_inf || b_inf) begin
            nxt_data = {s, 8'hFF, 23'd0};
        end else if (a_zero || b_zero) begin
            nxt_data = {s, 31'd0};
        end else if (texp >= 10'sd255) begin
            nxt_data = {s, 8'hFF, 23'd0};
            nxt_ovf  = 1'b1;
        end else if (texp <= 10'sd0) begin
            nxt_data = {s, 31'd0};
            nxt_udf  = 1'b1;
        end
    end

    // R1 payload: only loaded on accept, its contents are meaningless while
    // r1_valid is low, so it needs no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            r1_a   <= in_a;
            r1_b   <= in_b;
            r1_raw <= in_raw;
        end
    end

    // Valid bits and the output register. Whenever in_ready is high R1 is
    // either empty or emptying, so its valid simply follows in_valid. R2
    // holds its contents while stalled and reloads only on a transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            r1_valid  <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= 32'd0;
            out_ovf   <= 1'b0;
            out_udf   <= 1'b0;
            out_inv   <= 1'b0;
        end else begin
            if (in_ready) begin
                r1_valid <= in_valid;
            end
            if (adv2) begin
                out_valid <= r1_valid;
            end
            if (transfer) begin
                out_data <= nxt_data;
                out_ovf  <= nxt_ovf;
                out_udf  <= nxt_udf;
                out_inv  <= nxt_inv;
            end
        end
    end

`ifdef FMUL_STATS_EN
    // Statistics counters: count completed output handshakes only, and stick
    // at all-ones rather than wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_count  <= 16'd0;
            exc_count <= 16'd0;
        end else if (out_valid && out_ready) begin
            if (op_count != 16'hFFFF) begin
                op_count <= op_count + 16'd1;
            end
            if ((out_ovf || out_udf || out_inv) && (exc_count != 16'hFFFF)) begin
                exc_count <= exc_count + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fmul_result_stage.sv
// ---------------------------------------------------------------------------
// tb_fmul_result_stage
//
// Directed testbench for fmul_result_stage. Each vector carries hand-computed
// expected product and flags; backpressure and mid-flight reset sequences are
// driven cycle by cycle. Flags are compared packed as {ovf, udf, inv}.
// ---------------------------------------------------------------------------
module tb_fmul_result_stage;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic [31:0] in_raw;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_ovf;
    logic        out_udf;
    logic        out_inv;
`ifdef FMUL_STATS_EN
    logic [15:0] op_count;
    logic [15:0] exc_count;
`endif

    int vectors;
    int miscompares;

    localparam int NVEC = 14;
    logic [31:0] va   [NVEC];
    logic [31:0] vb   [NVEC];
    logic [31:0] vraw [NVEC];
    logic [31:0] vexp [NVEC];
    logic [2:0]  vfl  [NVEC];

    logic [31:0] bp_a   [4];
    logic [31:0] bp_b   [4];
    logic [31:0] bp_raw [4];

    fmul_result_stage dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_raw    (in_raw),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ovf   (out_ovf),
        .out_udf   (out_udf),
        .out_inv   (out_inv)
`ifdef FMUL_STATS_EN
        ,
        .op_count  (op_count),
        .exc_count (exc_count)
`endif
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] got,
                               input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Present one triple for one cycle, then wait until its result should be
    // sitting in the output register (two edges after presentation).
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] raw);
        in_a     = a;
        in_b     = b;
        in_raw   = raw;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        int exp_ops;
        int exp_exc;
        int sent;
        int popped;
        int first_pop;
        int last_pop;

        vectors     = 0;
        miscompares = 0;
        exp_ops     = 0;
        exp_exc     = 0;

        // a, b, raw, expected data, expected {ovf,udf,inv}
        va[0]  = 32'h3F800000; vb[0]  = 32'h3F800000; vraw[0]  = 32'h3F800000; vexp[0]  = 32'h3F800000; vfl[0]  = 3'b000;
        va[1]  = 32'h7F000000; vb[1]  = 32'h7F000000; vraw[1]  = 32'h3E800000; vexp[1]  = 32'h7F800000; vfl[1]  = 3'b100;
        va[2]  = 32'h7F800000; vb[2]  = 32'h00000000; vraw[2]  = 32'h00000000; vexp[2]  = 32'h7FC00000; vfl[2]  = 3'b001;
        va[3]  = 32'h7FC00001; vb[3]  = 32'h3F800000; vraw[3]  = 32'h7FC00001; vexp[3]  = 32'h7FC00000; vfl[3]  = 3'b001;
        va[4]  = 32'h00800000; vb[4]  = 32'h80800000; vraw[4]  = 32'h00000000; vexp[4]  = 32'h80000000; vfl[4]  = 3'b010;
        va[5]  = 32'h80000000; vb[5]  = 32'h40000000; vraw[5]  = 32'h80000000; vexp[5]  = 32'h80000000; vfl[5]  = 3'b000;
        va[6]  = 32'h7F800000; vb[6]  = 32'hC0000000; vraw[6]  = 32'hFF800000; vexp[6]  = 32'hFF800000; vfl[6]  = 3'b000;
        va[7]  = 32'h3FC00000; vb[7]  = 32'h3FC00000; vraw[7]  = 32'h40100000; vexp[7]  = 32'h40100000; vfl[7]  = 3'b000;
        va[8]  = 32'h7F400000; vb[8]  = 32'h3FC00000; vraw[8]  = 32'h7F900000; vexp[8]  = 32'h7F800000; vfl[8]  = 3'b100;
        va[9]  = 32'h7F000000; vb[9]  = 32'h3F800000; vraw[9]  = 32'h7F000000; vexp[9]  = 32'h7F000000; vfl[9]  = 3'b000;
        va[10] = 32'h00800000; vb[10] = 32'h3F000000; vraw[10] = 32'h00000000; vexp[10] = 32'h00000000; vfl[10] = 3'b010;
        va[11] = 32'h00800000; vb[11] = 32'h3F800000; vraw[11] = 32'h00800000; vexp[11] = 32'h00800000; vfl[11] = 3'b000;
        va[12] = 32'h00000001; vb[12] = 32'h3F800000; vraw[12] = 32'h00000001; vexp[12] = 32'h00000000; vfl[12] = 3'b000;
        va[13] = 32'h7FC00000; vb[13] = 32'h80000000; vraw[13] = 32'h7FC00000; vexp[13] = 32'h7FC00000; vfl[13] = 3'b001;

        bp_a[0] = 32'h3F800000; bp_b[0] = 32'h40000000; bp_raw[0] = 32'h40000000;
        bp_a[1] = 32'h3F800000; bp_b[1] = 32'h40400000; bp_raw[1] = 32'h40400000;
        bp_a[2] = 32'h3F800000; bp_b[2] = 32'h40800000; bp_raw[2] = 32'h40800000;
        bp_a[3] = 32'h3F800000; bp_b[3] = 32'h40A00000; bp_raw[3] = 32'h40A00000;

        // Reset state
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = 32'd0;
        in_b      = 32'd0;
        in_raw    = 32'd0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("rst_in_ready",  {31'd0, in_ready},  32'd1);
        checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("rst_out_data",  out_data,           32'd0);
        checkOutput("rst_flags",     {29'd0, out_ovf, out_udf, out_inv}, 32'd0);
`ifdef FMUL_STATS_EN
        checkOutput("rst_op_count",  {16'd0, op_count},  32'd0);
        checkOutput("rst_exc_count", {16'd0, exc_count}, 32'd0);
`endif

        // Directed vectors with out_ready held high
        for (int i = 0; i < NVEC; i++) begin
            checkOutput($sformatf("v%0d_in_ready", i), {31'd0, in_ready}, 32'd1);
            applyStimulus(va[i], vb[i], vraw[i]);
            checkOutput($sformatf("v%0d_valid", i), {31'd0, out_valid}, 32'd1);
            checkOutput($sformatf("v%0d_data", i), out_data, vexp[i]);
            checkOutput($sformatf("v%0d_flags", i),
                        {29'd0, out_ovf, out_udf, out_inv}, {29'd0, vfl[i]});
            exp_ops++;
            if (vfl[i] != 3'b000) exp_exc++;
        end
        @(posedge clk); #1;
        checkOutput("drain_valid", {31'd0, out_valid}, 32'd0);

        // Backpressure: 4 triples, consumer stalled for the first 4 cycles
        sent      = 0;
        popped    = 0;
        first_pop = -1;
        last_pop  = -1;
        for (int cyc = 0; cyc < 12; cyc++) begin
            logic acc;
            in_valid  = (sent < 4);
            in_a      = bp_a[sent % 4];
            in_b      = bp_b[sent % 4];
            in_raw    = bp_raw[sent % 4];
            out_ready = (cyc >= 4);
            @(negedge clk);
            if (cyc == 2 || cyc == 3) begin
                checkOutput($sformatf("bp_stall%0d_in_ready", cyc), {31'd0, in_ready}, 32'd0);
                checkOutput($sformatf("bp_stall%0d_accepts", cyc), sent, 32'd2);
                checkOutput($sformatf("bp_stall%0d_hold", cyc), out_data, bp_raw[0]);
            end
            if (out_valid && out_ready) begin
                if (popped < 4)
                    checkOutput($sformatf("bp_order%0d", popped), out_data, bp_raw[popped]);
                if (first_pop < 0) first_pop = cyc;
                last_pop = cyc;
                popped++;
            end
            acc = in_valid && in_ready;
            @(posedge clk); #1;
            if (acc) sent++;
        end
        in_valid = 1'b0;
        checkOutput("bp_total", popped, 32'd4);
        checkOutput("bp_first_pop", first_pop, 32'd4);
        checkOutput("bp_back_to_back", last_pop - first_pop, 32'd3);
        exp_ops += 4;

`ifdef FMUL_STATS_EN
        checkOutput("stats_op_count",  {16'd0, op_count},  exp_ops);
        checkOutput("stats_exc_count", {16'd0, exc_count}, exp_exc);
`endif

        // Reset with both stages occupied
        out_ready = 1'b0;
        in_a      = 32'h3F800000;
        in_b      = 32'h3F800000;
        in_raw    = 32'h3F800000;
        in_valid  = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        checkOutput("mid_pre_valid", {31'd0, out_valid}, 32'd1);
        checkOutput("mid_pre_in_ready", {31'd0, in_ready}, 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checkOutput("mid_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("mid_out_data",  out_data,           32'd0);
        checkOutput("mid_flags",     {29'd0, out_ovf, out_udf, out_inv}, 32'd0);
        checkOutput("mid_in_ready",  {31'd0, in_ready},  32'd1);
`ifdef FMUL_STATS_EN
        checkOutput("mid_op_count",  {16'd0, op_count},  32'd0);
        checkOutput("mid_exc_count", {16'd0, exc_count}, 32'd0);
`endif
        out_ready = 1'b1;
        @(posedge clk); #1;
        checkOutput("mid_r1_discarded", {31'd0, out_valid}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
